// File: rtl/drum_strike_detector.sv
// drum_strike_detector
//
// Turns the gyro-Y sample stream into discrete drum-strike events. A downward
// swing (negative gyro_y) whose magnitude reaches ARM_THRESH arms the detector.
// The peak magnitude is tracked while armed. The first sample whose magnitude
// drops below FIRE_THRESH fires one event carrying a 7-bit velocity derived
// from the peak. A refractory window then blocks re-triggers. Events are held
// in a single-entry register until the consumer accepts them.
//
// Ports:
//   clk_i              system clock (3 MHz nominal)
//   rst_ni             asynchronous active-low reset
//   gyro_valid_i       one-cycle strobe marking a new gyro sample
//   gyro_y_i           signed angular rate, negative = downward swing
//   strike_valid_o     event pending
//   strike_velocity_o  {1'b0, velocity[6:0]}
//   strike_ready_i     consumer accepts the event when high with strike_valid_o
//   armed_o            high while in the armed state
//   drop_count_o       saturating count of events lost to a pending event
module drum_strike_detector #(
    parameter logic [15:0] ARM_THRESH       = 16'd2000,
    parameter logic [15:0] FIRE_THRESH      = 16'd500,
    parameter int unsigned VEL_SHIFT        = 8,
    parameter logic [23:0] MAX_SWING_CYCLES = 24'd1_500_000,
    parameter logic [23:0] REFRACT_CYCLES   = 24'd150_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        gyro_valid_i,
    input  logic [15:0] gyro_y_i,
    output logic        strike_valid_o,
    output logic [7:0]  strike_velocity_o,
    input  logic        strike_ready_i,
    output logic        armed_o,
    output logic [7:0]  drop_count_o
);

    typedef enum logic [1:0] {StIdle, StArmed, StRefract} state_e;

    state_e      state_q, state_d;
    logic [15:0] peak_q, peak_d;
    logic [23:0] swing_cnt_q, swing_cnt_d;
    logic [23:0] refract_cnt_q, refract_cnt_d;
    logic        strike_valid_q, strike_valid_d;
    logic [7:0]  strike_vel_q, strike_vel_d;
    logic [7:0]  drop_count_q, drop_count_d;

    // Magnitude of downward rate. Negation done in 17 bits so -32768 does not
    // wrap; the result is clamped to 32767 to keep the magnitude positive.
    logic [16:0] neg_y;
    logic [15:0] mag;

    assign neg_y = 17'd0 - {gyro_y_i[15], gyro_y_i};

    always_comb begin
        mag = 16'd0;
        if (gyro_y_i[15]) begin
            if (neg_y > 17'd32767) begin
                mag = 16'h7fff;
            end else begin
                mag = neg_y[15:0];
            end
        end
    end

    // Peak including the sample currently being evaluated.
    logic [15:0] peak_eff;
    logic [15:0] peak_shifted;
    logic [6:0]  vel;

    assign peak_eff     = (mag > peak_q) ? mag : peak_q;
    assign peak_shifted = peak_eff >> VEL_SHIFT;
    assign vel          = (peak_shifted > 16'd127) ? 7'd127 : peak_shifted[6:0];

    logic emit;

    // Detector FSM.
    always_comb begin
        state_d       = state_q;
        peak_d        = peak_q;
        swing_cnt_d   = swing_cnt_q;
        refract_cnt_d = refract_cnt_q;
        emit          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gyro_valid_i && (mag >= ARM_THRESH)) begin
                    state_d     = StArmed;
                    peak_d      = mag;
                    swing_cnt_d = 24'd0;
                end
            end
            StArmed: begin
                swing_cnt_d = swing_cnt_q + 24'd1;
                // Fire takes priority over the swing timeout.
                if (gyro_valid_i && (mag < FIRE_THRESH)) begin
                    emit          = 1'b1;
                    state_d       = StRefract;
                    refract_cnt_d = REFRACT_CYCLES;
                end else begin
                    if (gyro_valid_i && (mag > peak_q)) begin
                        peak_d = mag;
                    end
                    if (swing_cnt_q == (MAX_SWING_CYCLES - 24'd1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StRefract: begin
                if (refract_cnt_q <= 24'd1) begin
                    refract_cnt_d = 24'd0;
                    state_d       = StIdle;
                end else begin
                    refract_cnt_d = refract_cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Single-entry event holding register. A new event loads only if the slot
    // is empty or being drained this cycle; otherwise it is dropped.
    logic accept;

    assign accept = strike_valid_q && strike_ready_i;

    always_comb begin
        strike_valid_d = strike_valid_q;
        strike_vel_d   = strike_vel_q;
        drop_count_d   = drop_count_q;

        if (emit && (!strike_valid_q || strike_ready_i)) begin
            strike_valid_d = 1'b1;
            strike_vel_d   = {1'b0, vel};
        end else if (emit) begin
            if (drop_count_q != 8'hff) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (accept) begin
            strike_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            peak_q         <= 16'd0;
            swing_cnt_q    <= 24'd0;
            refract_cnt_q  <= 24'd0;
            strike_valid_q <= 1'b0;
            strike_vel_q   <= 8'd0;
            drop_count_q   <= 8'd0;
        end else begin
            state_q        <= state_d;
            peak_q         <= peak_d;
            swing_cnt_q    <= swing_cnt_d;
            refract_cnt_q  <= refract_cnt_d;
            strike_valid_q <= strike_valid_d;
            strike_vel_q   <= strike_vel_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign strike_valid_o    = strike_valid_q;
    assign strike_velocity_o = strike_vel_q;
    assign armed_o           = (state_q == StArmed);
    assign drop_count_o      = drop_count_q;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Scoreboard bench for drum_strike_detector. Stimulus pushes expected strike
// velocities into a queue; a monitor pops and compares on every accepted event.
module tb_drum_strike_detector;

    localparam int R = 40;  // refractory cycles
    localparam int M = 60;  // max swing cycles

    logic        clk_i;
    logic        rst_ni;
    logic        gyro_valid_i;
    logic [15:0] gyro_y_i;
    logic        strike_valid_o;
    logic [7:0]  strike_velocity_o;
    logic        strike_ready_i;
    logic        armed_o;
    logic [7:0]  drop_count_o;

    drum_strike_detector #(
        .ARM_THRESH      (16'd2000),
        .FIRE_THRESH     (16'd500),
        .VEL_SHIFT       (8),
        .MAX_SWING_CYCLES(24'(M)),
        .REFRACT_CYCLES  (24'(R))
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .gyro_valid_i     (gyro_valid_i),
        .gyro_y_i         (gyro_y_i),
        .strike_valid_o   (strike_valid_o),
        .strike_velocity_o(strike_velocity_o),
        .strike_ready_i   (strike_ready_i),
        .armed_o          (armed_o),
        .drop_count_o     (drop_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted event must match the oldest expected velocity.
    always @(negedge clk_i) begin
        if (rst_ni && strike_valid_o && strike_ready_i) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got velocity %0d expected no event",
                         strike_velocity_o);
            end else begin
                check("strike_velocity", {24'd0, strike_velocity_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic sample(input int y);
        gyro_valid_i = 1'b1;
        gyro_y_i     = 16'(y);
        @(posedge clk_i);
        #1;
        gyro_valid_i = 1'b0;
        gyro_y_i     = 16'd0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        gyro_valid_i   = 1'b0;
        gyro_y_i       = 16'd0;
        strike_ready_i = 1'b1;
        #3;
        check("reset_valid", {31'd0, strike_valid_o}, 0);
        check("reset_velocity", {24'd0, strike_velocity_o}, 0);
        check("reset_armed", {31'd0, armed_o}, 0);
        check("reset_drop", {24'd0, drop_count_o}, 0);
        #9 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic swing: peak 9000 -> velocity 35.
        sample(-1000);
        check("armed_below_thresh", {31'd0, armed_o}, 0);
        sample(-3000);
        check("armed_after_arm", {31'd0, armed_o}, 1);
        sample(-9000);
        sample(-6000);
        exp_q.push_back(8'd35);
        sample(-200);
        check("valid_after_fire", {31'd0, strike_valid_o}, 1);
        check("armed_in_refract", {31'd0, armed_o}, 0);

        // Swing inside the refractory window is ignored.
        idle(9);
        sample(-3000);
        check("armed_during_refract", {31'd0, armed_o}, 0);
        sample(-9000);
        sample(-100);

        // Swing after the window fires: peak 5200 -> 20.
        idle(R + 2);
        sample(-3000);
        check("armed_after_refract", {31'd0, armed_o}, 1);
        sample(-5200);
        exp_q.push_back(8'd20);
        sample(-100);

        // Extreme sample -32768 -> clamped 32767 -> 127.
        idle(R + 2);
        sample(-32768);
        check("armed_extreme", {31'd0, armed_o}, 1);
        exp_q.push_back(8'd127);
        sample(-100);

        // Threshold boundaries.
        idle(R + 2);
        sample(5000);
        check("positive_no_arm", {31'd0, armed_o}, 0);
        sample(-1999);
        check("arm_1999", {31'd0, armed_o}, 0);
        sample(-2000);
        check("arm_2000", {31'd0, armed_o}, 1);
        sample(-500);
        check("no_fire_500", {31'd0, armed_o}, 1);
        exp_q.push_back(8'd7);
        sample(-499);
        check("fire_499", {31'd0, armed_o}, 0);

        // Swing timeout: armed lasts exactly M cycles, no event.
        idle(R + 2);
        sample(-2500);
        check("armed_timeout_start", {31'd0, armed_o}, 1);
        repeat (M - 1) sample(-2500);
        check("armed_before_timeout", {31'd0, armed_o}, 1);
        sample(-2500);
        check("armed_after_timeout", {31'd0, armed_o}, 0);
        idle(3);
        check("no_event_timeout", {31'd0, strike_valid_o}, 0);

        // Drop: second event while first pending is discarded.
        strike_ready_i = 1'b0;
        sample(-4000);
        exp_q.push_back(8'd15);
        sample(-100);
        idle(R + 2);
        sample(-2600);
        sample(-100);
        check("drop_valid_held", {31'd0, strike_valid_o}, 1);
        check("drop_velocity_held", {24'd0, strike_velocity_o}, 15);
        check("drop_count", {24'd0, drop_count_o}, 1);
        strike_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("valid_clears", {31'd0, strike_valid_o}, 0);

        // Reset while armed with an event pending.
        strike_ready_i = 1'b0;
        idle(R + 2);
        sample(-3000);
        sample(-100);
        idle(R + 2);
        sample(-3000);
        check("pre_reset_armed", {31'd0, armed_o}, 1);
        check("pre_reset_pending", {31'd0, strike_valid_o}, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, strike_valid_o}, 0);
        check("async_reset_velocity", {24'd0, strike_velocity_o}, 0);
        check("async_reset_armed", {31'd0, armed_o}, 0);
        check("async_reset_drop", {24'd0, drop_count_o}, 0);
        #2 rst_ni = 1'b1;
        strike_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        sample(-3000);
        exp_q.push_back(8'd11);
        sample(-100);
        idle(5);
        check("all_events_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drum_strike_detector.md
# drum_strike_detector

Turns the BNO085 controller's gyro stream into discrete drum-strike events for the MCU link. Sits directly downstream of the sensor controller's gyro outputs and upstream of the data formatter / MCU SPI slave. It detects a downward swing on gyro Y, tracks its peak, and fires one event when the stick decelerates. Each event carries a 7-bit velocity and is held until the consumer acknowledges it. A refractory window after each strike suppresses re-triggers.

## Interface
- ARM_THRESH, 16'd2000 — |gyro_y| (raw LSB) at or above which a downward swing arms the detector.
- FIRE_THRESH, 16'd500 — |gyro_y| below which an armed swing fires; must be < ARM_THRESH.
- VEL_SHIFT, 8 — right shift applied to the peak magnitude to form velocity.
- MAX_SWING_CYCLES, 24'd1_500_000 — armed-state timeout (0.5 s at 3 MHz).
- REFRACT_CYCLES, 24'd150_000 — post-strike lockout (50 ms at 3 MHz).
- clk  in  1  system clock (HSOSC-derived, 3 MHz nominal).
- rst_n  in  1  asynchronous active-low reset.
- gyro_valid  in  1  one-cycle pulse marking a new gyro sample.
- gyro_y  in  16  signed angular rate; negative = downward swing.
- strike_valid  out  1  event pending.
- strike_velocity  out  8  bit 7 = 0, bits 6:0 = velocity 0..127.
- strike_ready  in  1  consumer accepts the event when high with strike_valid.
- armed  out  1  high in the ARMED state (LED/debug).
- drop_count  out  8  saturating count of events lost because one was still pending.

## Operation
- Magnitude: mag = (gyro_y < 0) ? −gyro_y : 0, computed 17-bit, then clamped to 32767. This makes −32768 map to 32767. Non-negative samples give mag = 0.
- Velocity: vel = min(peak >> VEL_SHIFT, 127), zero-extended to 8 bits.
- FSM states are IDLE, ARMED and REFRACT. All transitions are evaluated only on cycles with gyro_valid = 1, except the timer-driven ones.
- IDLE: if gyro_valid and mag >= ARM_THRESH, go to ARMED. Load peak = mag and clear swing_cnt.
- ARMED, swing_cnt:
  - swing_cnt increments every clock.
  - On gyro_valid with mag > peak, update peak.
  - On gyro_valid with mag < FIRE_THRESH, emit an event with velocity from the peak, including the current sample. Go to REFRACT and load refract_cnt = REFRACT_CYCLES.
  - Timeout: if swing_cnt reaches MAX_SWING_CYCLES − 1 with no fire, go to IDLE with no event.
  - Fire has priority over timeout on the same cycle.
- REFRACT: refract_cnt decrements every clock. Samples are ignored. When it reaches 0, go to IDLE.
- Output holding register:
  - Emitting with strike_valid = 0 (or being accepted this same cycle): load velocity and set strike_valid.
  - Emitting while strike_valid = 1 and strike_ready = 0: the new event is discarded, the old event is kept, and drop_count increments, saturating at 255.
- Handshake: strike_valid and strike_velocity stay stable until a cycle with strike_ready = 1. strike_valid clears the following cycle unless a new event loads that same cycle.

## Timing
- Reset (async assert, sync deassert by top): all of the following are 0 — state = IDLE, peak, swing_cnt, refract_cnt, strike_valid, strike_velocity, armed, drop_count.
- Latency:
  - strike_valid rises on the clock edge after the gyro_valid cycle carrying the firing sample (1 cycle).
  - armed rises 1 cycle after the arming sample.
- Accept-and-reload on the same cycle: strike_valid stays 1 with the new velocity, and there is no drop.
- Reset mid-swing or while an event is pending loses the event and does not count a drop.
- gyro_valid back-to-back on consecutive cycles is legal. Each sample is evaluated independently.

## Test plan
- Swing profile: gyro_y samples −1000, −3000, −9000, −6000, −200 → armed high after the −3000 sample. One event fires after −200 with strike_velocity = 35 (9000 >> 8). The FSM then enters REFRACT.
- Extreme sample −32768 inside a swing, then −100 → strike_velocity = 127, with no overflow or sign error.
- Second full swing starting 10 cycles into REFRACT → no event. The same swing starting after REFRACT_CYCLES + 2 cycles → event fires.
- strike_ready held low while two strikes occur → first velocity retained, drop_count = 1. Release ready → strike_valid clears on the next cycle.
- Armed at −2500, then gyro_y held at −2500 beyond MAX_SWING_CYCLES → returns to IDLE, armed = 0, no event.
- Assert rst_n low while ARMED and with an event pending → all outputs read 0 asynchronously. A subsequent −3000, −100 swing produces velocity 11.
